ps2_mouse_packet: RTL and testbench
===================================

// Module: ps2_mouse_packet
// PURPOSE
//  Consumes the byte stream from the mouse-side PS/2 receiver once stream mode is acknowledged.
//  Frames the standard 3-byte movement packets and decodes buttons and signed X/Y deltas.
//  Integrates the deltas into a screen-clamped cursor position for the display logic.
// PARAMETERS
//  SCREEN_W     640         cursor X range 0..SCREEN_W-1
//  SCREEN_H     480         cursor Y range 0..SCREEN_H-1
//  CLK_HZ       25_000_000  clk frequency; used only for the timeout
//  TIMEOUT_US   2000        max inter-byte gap within a packet; used only for the timeout
// PORTS
//  clk          in   1      clock
//  rst          in   1      reset, synchronous, active-high
//  enable       in   1      high once the init FSM has the ACK (FA) to enable-data-reporting (F4)
//  rx_done_tick in   1      one-cycle strobe, rx_data valid
//  rx_data      in   8      received byte
//  pkt_valid    out  1      one-cycle strobe: btn/dx/dy/cursor updated
//  btn          out  3      {middle,right,left}, registered
//  dx           out  9      signed X delta of last packet (after overflow saturation)
//  dy           out  9      signed Y delta of last packet, mouse convention (+ = up)
//  cursor_x     out  XW     XW=$clog2(SCREEN_W)
//  cursor_y     out  YW     YW=$clog2(SCREEN_H); screen convention (+ = down)
//  sync_err     out  1      one-cycle strobe: byte discarded or packet aborted
// BEHAVIOUR
//  - Reset values: pkt_valid=0, sync_err=0, btn=0, dx=0, dy=0, state=B0.
//  - Reset values: cursor_x=SCREEN_W/2, cursor_y=SCREEN_H/2.
//  - FSM states: B0 -> B1 -> B2 -> B0. Advance only on rx_done_tick with enable=1.
//  - B0: accept byte only if bit3=1; latch it and go to B1.
//  - B0: if bit3=0, drop the byte, pulse sync_err, stay in B0.
//  - B1: latch X byte, go to B2.
//  - B2: latch Y byte, go to B0. On the next clk: pkt_valid=1 and all outputs updated together.
//    Latency: 1 cycle after the third tick.
//  - Decode: dx={b0[4],b1}, dy={b0[5],b2}, btn=b0[2:0].
//  - Overflow: b0[6] forces dx to +255 or -255, following the sign bit b0[4].
//    b0[7] does the same for dy using sign bit b0[5].
//  - Cursor X: next_x = cursor_x + dx, computed signed at XW+2 bits.
//  - Cursor Y: next_y = cursor_y - dy, computed signed at YW+2 bits.
//  - Clamp: saturate to [0, SCREEN_W-1] and [0, SCREEN_H-1]; never wraps.
//  - enable=0: state forced to B0 and any partial packet dropped silently (no sync_err).
//    Cursor is held. enable=0 wins over a coincident rx_done_tick.
//  - rst mid-packet: full reset; partial bytes dropped and cursor re-centred.
//  - Outputs are registered, with no combinational path from input to output.
// CONFIGURATION
//  Macro PS2_MOUSE_TIMEOUT_EN:
//  - Defined: counter of CLK_HZ/1_000_000*TIMEOUT_US cycles runs while state is B1 or B2.
//    Counter clears on each accepted byte.
//  - Defined, on expiry: state goes to B0 and sync_err pulses for 1 cycle.
//    Expiry coincident with rx_done_tick: the byte wins and the counter clears.
//  - Undefined: no counter; resync relies only on the bit3 check and on enable.
// STRUCTURE
//  - Package ps2_mouse_pkg holds:
//    - typedef enum {B0,B1,B2} pkt_state_t;
//    - packed struct mouse_pkt_t {btn[2:0], dx[8:0], dy[8:0]};
//    - constants ACK_BYTE=8'hFA, BAT_OK=8'hAA, ENABLE_REPORT=8'hF4, DELTA_MAX=255.
//  - Sub-module ps2_mouse_axis_acc (parameters MAX, W).
//    - Signed add, saturate and clamp for one axis; instantiated for X and for Y (with -dy).
// TESTING
//  - Reset, then packet 08,05,03 -> pkt_valid 1 cycle, btn=0, dx=+5, dy=+3, cursor=(325,237).
//  - Packet 39,FB,FE -> btn=1, dx=-5, dy=-2; cursor_x drops by 5, cursor_y rises by 2.
//  - Packet 48,10,00 at cursor_x=500 -> dx=+255, cursor_x=639 (clamped).
//    Repeating the packet keeps cursor_x=639.
//  - Stray byte 05 while in B0 -> sync_err pulse, no pkt_valid.
//    The following 08,01,01 then decodes correctly.
//  - enable drops after 2 bytes, then rises, then 08,02,00 arrives -> one pkt_valid, dx=+2, no sync_err.
//  - With PS2_MOUSE_TIMEOUT_EN (TIMEOUT_US=10): 08, then a gap > 10 us -> sync_err.
//    A fresh 08,01,00 then gives dx=+1.

Source files
------------

// File: rtl/ps2_mouse_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : ps2_mouse_pkg                                                  |
// | Brief   : Shared types, protocol bytes and packet decode for the mouse.  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package ps2_mouse_pkg;

    typedef enum logic [1:0] {
        B0 = 2'd0,
        B1 = 2'd1,
        B2 = 2'd2
    } pkt_state_t;

    typedef struct packed {
        logic [2:0] btn;
        logic [8:0] dx;
        logic [8:0] dy;
    } mouse_pkt_t;

    localparam logic [7:0] ACK_BYTE      = 8'hFA;
    localparam logic [7:0] BAT_OK        = 8'hAA;
    localparam logic [7:0] ENABLE_REPORT = 8'hF4;
    localparam int         DELTA_MAX     = 255;

    // An overflow flag replaces the 9-bit delta with the largest magnitude in its direction.
    function automatic logic [8:0] sat_delta(input logic ovf, input logic sign, input logic [7:0] mag);
        logic [8:0] v;
        if (ovf) begin
            v = sign ? 9'(-DELTA_MAX) : 9'(DELTA_MAX);
        end else begin
            v = {sign, mag};
        end
        return v;
    endfunction

    function automatic mouse_pkt_t decode_pkt(input logic [7:0] b0, input logic [7:0] b1,
                                              input logic [7:0] b2);
        mouse_pkt_t p;
        p.btn = b0[2:0];
        p.dx  = sat_delta(b0[6], b0[4], b1);
        p.dy  = sat_delta(b0[7], b0[5], b2);
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_mouse_axis_acc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : ps2_mouse_axis_acc                                             |
// | Brief   : One cursor axis: signed position + delta, clamped to 0..MAX-1. |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module ps2_mouse_axis_acc #(
    parameter int MAX = 640,
    parameter int W   = 10
) (
    input  logic        [W-1:0] i_pos,
    input  logic signed [9:0]   i_delta,
    output logic        [W-1:0] o_pos
);

    // Two guard bits hold any position plus a +/-256 delta without wrapping.
    localparam logic signed [W+1:0] c_hi = (W+2)'(MAX - 1);

    logic signed [W+1:0] w_pos_ext;
    logic signed [W+1:0] w_delta_ext;
    logic signed [W+1:0] w_sum;

    assign w_pos_ext   = $signed({2'b00, i_pos});
    assign w_delta_ext = (W+2)'(i_delta);
    assign w_sum       = w_pos_ext + w_delta_ext;

    always_comb begin
        o_pos = w_sum[W-1:0];
        if (w_sum < 0) begin
            o_pos = '0;
        end else if (w_sum > c_hi) begin
            o_pos = c_hi[W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_mouse_packet.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : ps2_mouse_packet                                               |
// | Brief   : Frames 3-byte PS/2 mouse packets, decodes buttons and deltas,  |
// |           integrates a screen-clamped cursor.                            |
// |           Optional PS2_MOUSE_TIMEOUT_EN: inter-byte timeout resync.      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module ps2_mouse_packet
    import ps2_mouse_pkg::*;
#(
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int CLK_HZ     = 25_000_000,
    parameter int TIMEOUT_US = 2000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        rx_done_tick,
    input  logic [7:0]                  rx_data,
    output logic                        pkt_valid,
    output logic [2:0]                  btn,
    output logic [8:0]                  dx,
    output logic [8:0]                  dy,
    output logic [$clog2(SCREEN_W)-1:0] cursor_x,
    output logic [$clog2(SCREEN_H)-1:0] cursor_y,
    output logic                        sync_err
);

    localparam int c_xw = $clog2(SCREEN_W);
    localparam int c_yw = $clog2(SCREEN_H);

    pkt_state_t r_state;
    pkt_state_t w_state_nxt;
    logic [7:0] r_b0;
    logic [7:0] r_b1;
    logic       w_latch_b0;
    logic       w_latch_b1;
    logic       w_pkt_done;
    logic       w_sync_err;
    logic       w_to_expired;

    mouse_pkt_t          w_pkt;
    logic signed [9:0]   w_dx_ext;
    logic signed [9:0]   w_dy_neg;
    logic [c_xw-1:0]     w_x_nxt;
    logic [c_yw-1:0]     w_y_nxt;

`ifdef PS2_MOUSE_TIMEOUT_EN
    localparam int c_to_cycles = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int c_to_w      = $clog2(c_to_cycles + 1);

    logic [c_to_w-1:0] r_to_cnt;

    // Counts idle cycles only while a packet is partially received.
    always_ff @(posedge clk) begin
        if (rst || !enable || rx_done_tick || r_state == B0 || w_to_expired) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_to_expired = (r_state != B0) && (r_to_cnt == c_to_w'(c_to_cycles - 1));
`else
    assign w_to_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= B0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch_b0  = 1'b0;
        w_latch_b1  = 1'b0;
        w_pkt_done  = 1'b0;
        w_sync_err  = 1'b0;
        if (!enable) begin
            w_state_nxt = B0;
        end else if (rx_done_tick) begin
            case (r_state)
                B0: begin
                    if (rx_data[3]) begin
                        w_latch_b0  = 1'b1;
                        w_state_nxt = B1;
                    end else begin
                        w_sync_err  = 1'b1;
                    end
                end
                B1: begin
                    w_latch_b1  = 1'b1;
                    w_state_nxt = B2;
                end
                B2: begin
                    w_pkt_done  = 1'b1;
                    w_state_nxt = B0;
                end
                default: w_state_nxt = B0;
            endcase
        end else if (w_to_expired) begin
            w_state_nxt = B0;
            w_sync_err  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_b0 <= '0;
            r_b1 <= '0;
        end else begin
            if (w_latch_b0) r_b0 <= rx_data;
            if (w_latch_b1) r_b1 <= rx_data;
        end
    end

    // The Y byte is decoded straight off rx_data so outputs land one cycle after the last tick.
    assign w_pkt    = decode_pkt(r_b0, r_b1, rx_data);
    assign w_dx_ext = $signed({w_pkt.dx[8], w_pkt.dx});
    assign w_dy_neg = -$signed({w_pkt.dy[8], w_pkt.dy});

    ps2_mouse_axis_acc #(.MAX(SCREEN_W), .W(c_xw)) u_acc_x (
        .i_pos   (cursor_x),
        .i_delta (w_dx_ext),
        .o_pos   (w_x_nxt)
    );

    ps2_mouse_axis_acc #(.MAX(SCREEN_H), .W(c_yw)) u_acc_y (
        .i_pos   (cursor_y),
        .i_delta (w_dy_neg),
        .o_pos   (w_y_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_valid <= 1'b0;
            sync_err  <= 1'b0;
            btn       <= '0;
            dx        <= '0;
            dy        <= '0;
            cursor_x  <= c_xw'(SCREEN_W / 2);
            cursor_y  <= c_yw'(SCREEN_H / 2);
        end else begin
            pkt_valid <= w_pkt_done;
            sync_err  <= w_sync_err;
            if (w_pkt_done) begin
                btn      <= w_pkt.btn;
                dx       <= w_pkt.dx;
                dy       <= w_pkt.dy;
                cursor_x <= w_x_nxt;
                cursor_y <= w_y_nxt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_mouse_packet.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_ps2_mouse_packet                                            |
// | Brief   : Directed self-checking bench for ps2_mouse_packet.             |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_ps2_mouse_packet;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       pkt_valid;
    logic [2:0] btn;
    logic [8:0] dx;
    logic [8:0] dy;
    logic [9:0] cursor_x;
    logic [8:0] cursor_y;
    logic       sync_err;

    int checks = 0;
    int errors = 0;
    int pv_cnt = 0;
    int se_cnt = 0;

    ps2_mouse_packet #(
        .SCREEN_W   (640),
        .SCREEN_H   (480),
        .CLK_HZ     (25_000_000),
        .TIMEOUT_US (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .pkt_valid    (pkt_valid),
        .btn          (btn),
        .dx           (dx),
        .dy           (dy),
        .cursor_x     (cursor_x),
        .cursor_y     (cursor_y),
        .sync_err     (sync_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pkt_valid === 1'b1) pv_cnt <= pv_cnt + 1;
        if (sync_err === 1'b1) se_cnt <= se_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data      = b;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        idle(3);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        checks++;
        if (pkt_valid !== 1'b0 || sync_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes pkt_valid=%b sync_err=%b expected 0 0", pkt_valid, sync_err);
        end
        checks++;
        if (btn !== 3'd0 || dx !== 9'd0 || dy !== 9'd0) begin
            errors++;
            $display("FAIL reset_decode btn=%h dx=%h dy=%h expected 0 0 0", btn, dx, dy);
        end
        checks++;
        if (cursor_x !== 10'd320 || cursor_y !== 9'd240) begin
            errors++;
            $display("FAIL reset_cursor got (%0d,%0d) expected (320,240)", cursor_x, cursor_y);
        end
        rst = 1'b0;
        enable = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        int base;
        base = pv_cnt;
        send_byte(8'h08);
        send_byte(8'h05);
        send_byte(8'h03);
        checks++;
        if (pkt_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency pkt_valid=%b expected 1", pkt_valid);
        end
        @(negedge clk);
        checks++;
        if (pkt_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse_width pkt_valid=%b expected 0", pkt_valid);
        end
        idle(2);
        checks++;
        if (btn !== 3'd0 || dx !== 9'h005 || dy !== 9'h003) begin
            errors++;
            $display("FAIL basic_decode btn=%h dx=%h dy=%h expected 0 005 003", btn, dx, dy);
        end
        checks++;
        if (cursor_x !== 10'd325 || cursor_y !== 9'd237) begin
            errors++;
            $display("FAIL basic_cursor got (%0d,%0d) expected (325,237)", cursor_x, cursor_y);
        end
        checks++;
        if (pv_cnt - base !== 1) begin
            errors++;
            $display("FAIL basic_pulse_count got %0d expected 1", pv_cnt - base);
        end
    endtask

    task automatic test_negative();
        send_pkt(8'h39, 8'hFB, 8'hFE);
        checks++;
        if (btn !== 3'd1 || dx !== 9'h1FB || dy !== 9'h1FE) begin
            errors++;
            $display("FAIL negative_decode btn=%h dx=%h dy=%h expected 1 1fb 1fe", btn, dx, dy);
        end
        checks++;
        if (cursor_x !== 10'd320 || cursor_y !== 9'd239) begin
            errors++;
            $display("FAIL negative_cursor got (%0d,%0d) expected (320,239)", cursor_x, cursor_y);
        end
    endtask

    task automatic test_clamp_x();
        send_pkt(8'h08, 8'hB4, 8'h00);
        checks++;
        if (cursor_x !== 10'd500 || dx !== 9'h0B4) begin
            errors++;
            $display("FAIL clamp_x_setup x=%0d dx=%h expected 500 0b4", cursor_x, dx);
        end
        send_pkt(8'h48, 8'h10, 8'h00);
        checks++;
        if (dx !== 9'h0FF || cursor_x !== 10'd639) begin
            errors++;
            $display("FAIL clamp_x_overflow dx=%h x=%0d expected 0ff 639", dx, cursor_x);
        end
        send_pkt(8'h48, 8'h10, 8'h00);
        checks++;
        if (cursor_x !== 10'd639 || cursor_y !== 9'd239) begin
            errors++;
            $display("FAIL clamp_x_hold got (%0d,%0d) expected (639,239)", cursor_x, cursor_y);
        end
    endtask

    task automatic test_clamp_y();
        send_pkt(8'h88, 8'h00, 8'h00);
        checks++;
        if (dy !== 9'h0FF || cursor_y !== 9'd0) begin
            errors++;
            $display("FAIL clamp_y_low dy=%h y=%0d expected 0ff 0", dy, cursor_y);
        end
        send_pkt(8'h28, 8'h00, 8'h00);
        checks++;
        if (dy !== 9'h100 || cursor_y !== 9'd256) begin
            errors++;
            $display("FAIL dy_min dy=%h y=%0d expected 100 256", dy, cursor_y);
        end
        send_pkt(8'h58, 8'h00, 8'h00);
        checks++;
        if (dx !== 9'h101 || cursor_x !== 10'd384 || cursor_y !== 9'd256) begin
            errors++;
            $display("FAIL dx_neg_overflow dx=%h cursor=(%0d,%0d) expected 101 (384,256)", dx, cursor_x, cursor_y);
        end
    endtask

    task automatic test_sync_err();
        int pv_base;
        int se_base;
        pv_base = pv_cnt;
        se_base = se_cnt;
        send_byte(8'h05);
        checks++;
        if (sync_err !== 1'b1) begin
            errors++;
            $display("FAIL stray_sync_err sync_err=%b expected 1", sync_err);
        end
        idle(3);
        checks++;
        if (se_cnt - se_base !== 1 || pv_cnt - pv_base !== 0) begin
            errors++;
            $display("FAIL stray_counts sync_err=%0d pkt_valid=%0d expected 1 0", se_cnt - se_base, pv_cnt - pv_base);
        end
        send_pkt(8'h08, 8'h01, 8'h01);
        checks++;
        if (dx !== 9'h001 || dy !== 9'h001 || cursor_x !== 10'd385 || cursor_y !== 9'd255) begin
            errors++;
            $display("FAIL resync_packet dx=%h dy=%h cursor=(%0d,%0d) expected 001 001 (385,255)", dx, dy, cursor_x, cursor_y);
        end
    endtask

    task automatic test_enable_drop();
        int pv_base;
        int se_base;
        pv_base = pv_cnt;
        se_base = se_cnt;
        send_byte(8'h08);
        send_byte(8'h03);
        enable = 1'b0;
        send_byte(8'h08);
        idle(2);
        enable = 1'b1;
        idle(1);
        send_pkt(8'h08, 8'h02, 8'h00);
        checks++;
        if (pv_cnt - pv_base !== 1 || se_cnt - se_base !== 0) begin
            errors++;
            $display("FAIL enable_counts pkt_valid=%0d sync_err=%0d expected 1 0", pv_cnt - pv_base, se_cnt - se_base);
        end
        checks++;
        if (dx !== 9'h002 || dy !== 9'h000 || cursor_x !== 10'd387 || cursor_y !== 9'd255) begin
            errors++;
            $display("FAIL enable_packet dx=%h dy=%h cursor=(%0d,%0d) expected 002 000 (387,255)", dx, dy, cursor_x, cursor_y);
        end
    endtask

    task automatic test_reset_mid_packet();
        send_byte(8'h08);
        send_byte(8'h05);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
        checks++;
        if (cursor_x !== 10'd320 || cursor_y !== 9'd240 || dx !== 9'd0) begin
            errors++;
            $display("FAIL midreset_state cursor=(%0d,%0d) dx=%h expected (320,240) 000", cursor_x, cursor_y, dx);
        end
        send_pkt(8'h08, 8'h01, 8'h00);
        checks++;
        if (dx !== 9'h001 || cursor_x !== 10'd321 || cursor_y !== 9'd240) begin
            errors++;
            $display("FAIL midreset_packet dx=%h cursor=(%0d,%0d) expected 001 (321,240)", dx, cursor_x, cursor_y);
        end
    endtask

`ifdef PS2_MOUSE_TIMEOUT_EN
    task automatic test_timeout();
        int se_base;
        int pv_base;
        se_base = se_cnt;
        send_byte(8'h08);
        idle(300);
        checks++;
        if (se_cnt - se_base !== 1) begin
            errors++;
            $display("FAIL timeout_sync_err count=%0d expected 1", se_cnt - se_base);
        end
        pv_base = pv_cnt;
        send_pkt(8'h08, 8'h01, 8'h00);
        checks++;
        if (pv_cnt - pv_base !== 1 || dx !== 9'h001 || cursor_x !== 10'd322) begin
            errors++;
            $display("FAIL timeout_resync pkt=%0d dx=%h x=%0d expected 1 001 322", pv_cnt - pv_base, dx, cursor_x);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_clamp_x();
        test_clamp_y();
        test_sync_err();
        test_enable_drop();
        test_reset_mid_packet();
`ifdef PS2_MOUSE_TIMEOUT_EN
        test_timeout();
`endif
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
